mixer_n: RTL and testbench

- Parametrised successor to the fixed 10-voice mixer: sums N_VOICES signed voice samples per audio frame into one signed OUT_W output sample, then pulses o_rdy.
- Sits between the voice bank (one sample per enabled cycle) and the output codec path.
- Adds per-frame attenuation (arithmetic shift), selectable clip or carry-over mode, frame resync via i_sof, and clip/error flags.
- Accumulates exactly (no intermediate saturation) and applies saturation once per frame.

---
 rtl/mixer_n_if.sv | 28 ++
 rtl/mixer_n.sv | 121 ++++++++++++
 tb/tb_mixer_n.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mixer_n_if.sv
// Sample/control bundle between the voice bank, the mixer and the codec path.
// The master drives samples and frame controls; the slave returns the mixed result.
interface mixer_n_if #(
  parameter int IN_W    = 23,
  parameter int OUT_W   = 24,
  parameter int SHIFT_W = 3
);
  logic                      clk_en;
  logic                      i_valid;
  logic                      i_sof;
  logic signed [IN_W-1:0]    i_data;
  logic        [SHIFT_W-1:0] i_shift;
  logic                      i_mode;
  logic signed [OUT_W-1:0]   o_mixed;
  logic                      o_rdy;
  logic                      o_clip;
  logic                      o_err;

  modport master (
    output clk_en, i_valid, i_sof, i_data, i_shift, i_mode,
    input  o_mixed, o_rdy, o_clip, o_err
  );

  modport slave (
    input  clk_en, i_valid, i_sof, i_data, i_shift, i_mode,
    output o_mixed, o_rdy, o_clip, o_err
  );
endinterface

// File: rtl/mixer_n.sv
// N-voice frame mixer: exact accumulation, per-frame attenuation, then one
// saturation step to OUT_W with optional carry-over of the clipped residue.
module mixer_n #(
  parameter int N_VOICES = 10,
  parameter int IN_W     = 23,
  parameter int OUT_W    = 24,
  parameter int SHIFT_W  = 3,
  parameter int ACC_W    = IN_W + $clog2(N_VOICES) + 2
) (
  input logic      clk,
  input logic      rst_n,
  mixer_n_if.slave bus
);

  localparam int CNT_W = $clog2(N_VOICES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_VOICES - 1);

  localparam logic signed [ACC_W:0]   ACC_MAX_X = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]   ACC_MIN_X = {2'b11, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] OUT_MAX_A = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN_A = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  if (N_VOICES < 2)    $error("mixer_n: N_VOICES must be at least 2");
  if (OUT_W < IN_W)    $error("mixer_n: OUT_W must be at least IN_W");
  if (ACC_W < OUT_W)   $error("mixer_n: ACC_W must be at least OUT_W");

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] v);
    if (v > ACC_MAX_X)      return ACC_MAX_X[ACC_W-1:0];
    else if (v < ACC_MIN_X) return ACC_MIN_X[ACC_W-1:0];
    else                    return v[ACC_W-1:0];
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
    if (v > OUT_MAX_A)      return OUT_MAX_A[OUT_W-1:0];
    else if (v < OUT_MIN_A) return OUT_MIN_A[OUT_W-1:0];
    else                    return v[OUT_W-1:0];
  endfunction

  logic signed [ACC_W-1:0] acc_q, acc_d, carry_q, carry_d;
  logic        [CNT_W-1:0] count_q, count_d;
  logic signed [OUT_W-1:0] mixed_q, mixed_d;
  logic                    clip_q, clip_d, rdy_q, rdy_d, err_q, err_d;

  logic                    accept;
  logic signed [ACC_W-1:0] sample_x, sum, att, total, mixed_x;
  logic signed [OUT_W-1:0] mixed_sat;

  assign accept   = bus.clk_en & bus.i_valid;
  assign sample_x = ACC_W'(bus.i_data);

  // Frame-end datapath; only consumed on the closing sample of a frame.
  always_comb begin
    sum       = acc_q + sample_x;
    att       = sum >>> bus.i_shift;
    total     = sat_acc({att[ACC_W-1], att} +
                        (bus.i_mode ? {carry_q[ACC_W-1], carry_q} : '0));
    mixed_sat = sat_out(total);
    mixed_x   = ACC_W'(mixed_sat);
  end

  // NOTE: every next-state variable gets a default first so no path leaves it
  // unassigned; otherwise always_comb would infer a latch.
  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    carry_d = carry_q;
    mixed_d = mixed_q;
    clip_d  = clip_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    if (accept) begin
      if (count_q == '0) begin
        acc_d   = sample_x;
        count_d = CNT_W'(1);
      end else if (bus.i_sof) begin
        acc_d   = sample_x;
        count_d = CNT_W'(1);
        err_d   = 1'b1;
      end else if (count_q == LAST) begin
        mixed_d = mixed_sat;
        clip_d  = (total != mixed_x);
        carry_d = bus.i_mode ? sat_acc({total[ACC_W-1], total} - {mixed_x[ACC_W-1], mixed_x})
                             : '0;
        acc_d   = '0;
        count_d = '0;
        rdy_d   = 1'b1;
      end else begin
        acc_d   = sum;
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q   <= '0;
      carry_q <= '0;
      count_q <= '0;
      mixed_q <= '0;
      clip_q  <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
      count_q <= count_d;
      mixed_q <= mixed_d;
      clip_q  <= clip_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_mixed = mixed_q;
  assign bus.o_clip  = clip_q;
  assign bus.o_rdy   = rdy_q;
  assign bus.o_err   = err_q;

endmodule

// File: tb/tb_mixer_n.sv
// Directed bench for mixer_n: hand-computed frames covering reset, range,
// clipping, carry-over, attenuation and i_sof resync.
module tb_mixer_n;
  localparam int N_VOICES = 10;
  localparam int IN_W     = 23;
  localparam int OUT_W    = 24;
  localparam int SHIFT_W  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mixer_n_if #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) bus ();

  mixer_n #(
    .N_VOICES(N_VOICES), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One accepted sample; 'gap' idle cycles first with i_valid high but clk_en low.
  task automatic send(input int d, input logic sof, input int gap);
    repeat (gap) begin
      bus.clk_en  = 1'b0;
      bus.i_valid = 1'b1;
      bus.i_data  = IN_W'(d);
      @(posedge clk); #1;
    end
    bus.clk_en  = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_sof   = sof;
    bus.i_data  = IN_W'(d);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    bus.i_sof   = 1'b0;
  endtask

  task automatic frame(input string tag, input int d, input int shift, input int mode,
                       input int gap, input int exp_m, input logic exp_c);
    bus.i_shift = SHIFT_W'(shift);
    bus.i_mode  = mode[0];
    for (int i = 0; i < N_VOICES - 1; i++) send(d, 1'b0, gap);
    check({tag, " rdy_before_last"}, 64'(bus.o_rdy), 64'd0);
    send(d, 1'b0, gap);
    check({tag, " rdy"}, 64'(bus.o_rdy), 64'd1);
    check({tag, " mixed"}, 64'(bus.o_mixed), 64'(exp_m));
    check({tag, " clip"}, 64'(bus.o_clip), 64'(exp_c));
    check({tag, " err"}, 64'(bus.o_err), 64'd0);
    @(posedge clk); #1;
    check({tag, " rdy_drop"}, 64'(bus.o_rdy), 64'd0);
    check({tag, " mixed_hold"}, 64'(bus.o_mixed), 64'(exp_m));
  endtask

  initial begin
    bus.clk_en  = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_sof   = 1'b0;
    bus.i_data  = '0;
    bus.i_shift = '0;
    bus.i_mode  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset mixed", 64'(bus.o_mixed), 64'd0);
    check("reset rdy", 64'(bus.o_rdy), 64'd0);
    check("reset err", 64'(bus.o_err), 64'd0);
    check("reset clip", 64'(bus.o_clip), 64'd0);
    rst_n = 1'b1;

    frame("in_range", 1000, 0, 0, 0, 10000, 1'b0);
    frame("gapped", 1000, 0, 0, 2, 10000, 1'b0);
    frame("clip_pos", 1048576, 0, 0, 0, 8388607, 1'b1);
    frame("clip_neg", -1048576, 0, 0, 0, -8388608, 1'b1);

    // Carry-over: residue 2097153 drains into the next frame, then is gone.
    frame("carry_load", 1048576, 0, 1, 0, 8388607, 1'b1);
    frame("carry_drain", 0, 0, 1, 0, 2097153, 1'b0);
    frame("carry_empty", 0, 0, 1, 0, 0, 1'b0);

    // A clip-mode frame end discards any pending residue.
    frame("carry_load2", 1048576, 0, 1, 0, 8388607, 1'b1);
    frame("clip_clears", 0, 0, 0, 0, 0, 1'b0);
    frame("after_clear", 0, 0, 1, 0, 0, 1'b0);

    frame("atten_neg", -3, 2, 0, 0, -8, 1'b0);
    frame("atten_big", 4194303, 3, 0, 0, 5242878, 1'b0);

    // Early i_sof on the 7th sample restarts the frame at that sample.
    bus.i_shift = '0;
    bus.i_mode  = 1'b0;
    for (int i = 0; i < 6; i++) send(5, 1'b0, 0);
    send(5, 1'b1, 0);
    check("resync err", 64'(bus.o_err), 64'd1);
    check("resync no_rdy", 64'(bus.o_rdy), 64'd0);
    send(5, 1'b0, 0);
    check("resync err_drop", 64'(bus.o_err), 64'd0);
    for (int i = 0; i < 8; i++) send(5, 1'b0, 0);
    check("resync rdy", 64'(bus.o_rdy), 64'd1);
    check("resync mixed", 64'(bus.o_mixed), 64'd50);

    // i_sof on what would be the closing sample aborts the frame instead.
    for (int i = 0; i < 9; i++) send(7, 1'b0, 0);
    send(7, 1'b1, 0);
    check("late_sof err", 64'(bus.o_err), 64'd1);
    check("late_sof no_rdy", 64'(bus.o_rdy), 64'd0);
    check("late_sof mixed_hold", 64'(bus.o_mixed), 64'd50);
    for (int i = 0; i < 9; i++) send(7, 1'b0, 0);
    check("late_sof rdy", 64'(bus.o_rdy), 64'd1);
    check("late_sof mixed", 64'(bus.o_mixed), 64'd70);

    // Reset mid-frame with pending carry; inputs keep accepting during reset.
    frame("pre_reset", 1048576, 0, 1, 0, 8388607, 1'b1);
    for (int i = 0; i < 5; i++) send(1000, 1'b0, 0);
    rst_n       = 1'b0;
    bus.clk_en  = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_sof   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_sof   = 1'b0;
    check("midreset mixed", 64'(bus.o_mixed), 64'd0);
    check("midreset rdy", 64'(bus.o_rdy), 64'd0);
    check("midreset err", 64'(bus.o_err), 64'd0);
    check("midreset clip", 64'(bus.o_clip), 64'd0);
    rst_n = 1'b1;
    frame("post_reset", 1000, 0, 1, 0, 10000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
